// File: rtl/stream_proc_chain.sv
// rtl/stream_proc_chain.sv - valid/ready stream chain: input FIFO -> mode-selectable op stage -> output FIFO
//
// Build macro: STREAM_PROC_CNT_EN adds saturating in_cnt/out_cnt transfer counters.
//
// stream_proc_fifo ports:
//   clk, rst (async active-low), push/push_data, pop, head (0 when empty), full, empty, level
// stream_proc_chain ports:
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   up_data/up_valid/up_ready        upstream handshake (up_ready independent of up_valid)
//   down_data/down_valid/down_ready  downstream handshake
//   mode                     00 pass, 01 wrap add, 10 invert, 11 saturating add
//   in_level/out_level       FIFO occupancies
//   in_cnt/out_cnt           (macro only) accepted / delivered word counters, saturating

module stream_proc_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Push is refused while full even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = count;
    // Head comes straight out of the storage flops; forced to 0 when empty so
    // the output is clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Explicit wrap so any depth works, not only powers of two.
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module stream_proc_chain #(
    parameter int D_WIDTH   = 6,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4,
    parameter int ADD_CONST = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [D_WIDTH-1:0]               up_data,
    input  logic                             up_valid,
    output logic                             up_ready,
    output logic [D_WIDTH-1:0]               down_data,
    output logic                             down_valid,
    input  logic                             down_ready,
    input  logic [1:0]                       mode,
    output logic [$clog2(IN_DEPTH+1)-1:0]    in_level,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   out_level
`ifdef STREAM_PROC_CNT_EN
    ,
    output logic [15:0]                      in_cnt,
    output logic [15:0]                      out_cnt
`endif
);
    logic               in_full;
    logic               in_empty;
    logic [D_WIDTH-1:0] in_head;
    logic               in_pop;
    logic               up_fire;

    logic               stage_valid;
    logic [D_WIDTH-1:0] stage_data;
    logic               stage_ready;

    logic               out_full;
    logic               out_empty;
    logic               out_push;
    logic               down_fire;

    logic [D_WIDTH:0]   sum_ext;
    logic [D_WIDTH-1:0] op_data;

    // Gating with rst keeps up_ready low for the whole reset window.
    assign up_ready    = rst && !in_full;
    assign up_fire     = up_valid && up_ready;
    assign stage_ready = !stage_valid || !out_full;
    assign in_pop      = !in_empty && stage_ready;
    assign out_push    = stage_valid && !out_full;
    assign down_valid  = !out_empty;
    assign down_fire   = down_valid && down_ready;

    stream_proc_fifo #(
        .W     (D_WIDTH),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (up_fire),
        .push_data (up_data),
        .pop       (in_pop),
        .head      (in_head),
        .full      (in_full),
        .empty     (in_empty),
        .level     (in_level)
    );

    // One extra bit on the sum so the saturating mode sees the carry.
    always_comb begin
        sum_ext = {1'b0, in_head} + (D_WIDTH + 1)'(ADD_CONST);
        op_data = in_head;
        case (mode)
            2'b01:   op_data = sum_ext[D_WIDTH-1:0];
            2'b10:   op_data = ~in_head;
            2'b11:   op_data = sum_ext[D_WIDTH] ? '1 : sum_ext[D_WIDTH-1:0];
            default: op_data = in_head;
        endcase
    end

    // mode is applied at the capture edge, so a change only affects words
    // captured afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (in_pop) begin
            stage_valid <= 1'b1;
            stage_data  <= op_data;
        end else if (out_push) begin
            stage_valid <= 1'b0;
        end
    end

    stream_proc_fifo #(
        .W     (D_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_push),
        .push_data (stage_data),
        .pop       (down_fire),
        .head      (down_data),
        .full      (out_full),
        .empty     (out_empty),
        .level     (out_level)
    );

`ifdef STREAM_PROC_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (up_fire && (in_cnt != 16'hFFFF)) begin
                in_cnt <= in_cnt + 16'd1;
            end
            if (down_fire && (out_cnt != 16'hFFFF)) begin
                out_cnt <= out_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_proc_chain.sv
// tb/tb_stream_proc_chain.sv - directed self-checking bench for stream_proc_chain
module tb_stream_proc_chain;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [5:0] up_data, down_data;
    logic       up_valid, up_ready, down_valid, down_ready;
    logic [1:0] mode;
    logic [2:0] in_level, out_level;

    logic [5:0] up_data2, down_data2;
    logic       up_valid2, up_ready2, down_valid2, down_ready2;
    logic [1:0] mode2;
    logic [1:0] in_level2;
    logic [2:0] out_level2;

`ifdef STREAM_PROC_CNT_EN
    logic [15:0] in_cnt, out_cnt, in_cnt2, out_cnt2;
`endif

    stream_proc_chain dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_valid (down_valid),
        .down_ready (down_ready),
        .mode       (mode),
        .in_level   (in_level),
        .out_level  (out_level)
`ifdef STREAM_PROC_CNT_EN
        ,
        .in_cnt     (in_cnt),
        .out_cnt    (out_cnt)
`endif
    );

    stream_proc_chain #(
        .D_WIDTH   (6),
        .IN_DEPTH  (3),
        .OUT_DEPTH (5),
        .ADD_CONST (1)
    ) dut2 (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data2),
        .up_valid   (up_valid2),
        .up_ready   (up_ready2),
        .down_data  (down_data2),
        .down_valid (down_valid2),
        .down_ready (down_ready2),
        .mode       (mode2),
        .in_level   (in_level2),
        .out_level  (out_level2)
`ifdef STREAM_PROC_CNT_EN
        ,
        .in_cnt     (in_cnt2),
        .out_cnt    (out_cnt2)
`endif
    );

    int         n_run = 0;
    int         n_fail = 0;
    int         idx, rx, errs, first_c, last_c, max_in, max_out;
    logic       acc, dacc;
    logic [5:0] g, exp_d;
    logic [5:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Send one word through the default DUT and return what comes out.
    task automatic xfer(input logic [5:0] d, input logic [1:0] m, output logic [5:0] got);
        int w;
        mode = m;
        up_data = d;
        up_valid = 1'b1;
        down_ready = 1'b1;
        w = 0;
        while (!up_ready && w < 20) begin
            tick;
            w++;
        end
        tick;
        up_valid = 1'b0;
        got = 'x;
        for (int i = 0; i < 20; i++) begin
            if (down_valid) begin
                got = down_data;
                break;
            end
            tick;
        end
        tick;
    endtask

    initial begin
        rst = 1'b0;
        up_valid = 0; up_data = 0; down_ready = 0; mode = 0;
        up_valid2 = 0; up_data2 = 0; down_ready2 = 0; mode2 = 0;
        repeat (3) tick;

        check("rst_up_ready", up_ready, 0);
        check("rst_down_valid", down_valid, 0);
        check("rst_down_data", down_data, 0);
        check("rst_in_level", in_level, 0);
        check("rst_out_level", out_level, 0);
`ifdef STREAM_PROC_CNT_EN
        check("rst_in_cnt", in_cnt, 0);
        check("rst_out_cnt", out_cnt, 0);
`endif
        rst = 1'b1;
        tick;
        check("ready_after_rst", up_ready, 1);

        // Single word latency, mode 01
        mode = 2'b01; up_data = 6'h05; up_valid = 1; down_ready = 1;
        tick;
        up_valid = 0;
        check("lat_n_valid", down_valid, 0);
        check("lat_n_in_level", in_level, 1);
        tick;
        check("lat_n1_valid", down_valid, 0);
        tick;
        check("lat_n2_valid", down_valid, 1);
        check("lat_n2_data", down_data, 6'h06);
        tick;
        check("lat_n3_valid", down_valid, 0);

        // Operation table
        xfer(6'h3F, 2'b11, g); check("sat_3f", g, 6'h3F);
        xfer(6'h3F, 2'b01, g); check("wrap_3f", g, 6'h00);
        xfer(6'h15, 2'b10, g); check("inv_15", g, 6'h2A);
        xfer(6'h0A, 2'b00, g); check("pass_0a", g, 6'h0A);
        xfer(6'h3E, 2'b11, g); check("sat_3e", g, 6'h3F);
        xfer(6'h20, 2'b11, g); check("sat_20", g, 6'h21);

        // Backpressure fill
        down_ready = 0; mode = 2'b00; idx = 0;
        for (int c = 0; c < 30; c++) begin
            up_data = 6'(idx); up_valid = 1;
            acc = up_ready;
            tick;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 9);
        check("bp_up_ready", up_ready, 0);
        check("bp_in_level", in_level, 4);
        check("bp_out_level", out_level, 4);
        check("bp_head", down_data, 0);
        down_ready = 1; rx = 0; errs = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 80 && rx < 21; c++) begin
            up_valid = (idx < 21); up_data = 6'(idx);
            acc = up_valid && up_ready;
            if (down_valid) begin
                if (down_data !== 6'(rx)) errs++;
                if (rx == 0) first_c = c;
                last_c = c;
                rx++;
            end
            tick;
            if (acc) idx++;
        end
        up_valid = 0;
        check("bp_rx", rx, 21);
        check("bp_order", errs, 0);
        check("bp_nogap", last_c - first_c, 20);

        // Non-power-of-two depths, random handshakes
        mode2 = 2'b01; idx = 0; rx = 0; errs = 0; max_in = 0; max_out = 0;
        for (int c = 0; c < 4000 && rx < 200; c++) begin
            if (!up_valid2 && idx < 200 && $urandom_range(0, 3) != 0) begin
                up_valid2 = 1;
                up_data2 = 6'($urandom_range(0, 63));
            end
            down_ready2 = ($urandom_range(0, 2) != 0);
            acc = up_valid2 && up_ready2;
            dacc = down_valid2 && down_ready2;
            if (int'(in_level2) > max_in) max_in = int'(in_level2);
            if (int'(out_level2) > max_out) max_out = int'(out_level2);
            if (dacc) begin
                if (q.size() == 0) errs++;
                else begin
                    exp_d = q.pop_front();
                    if (down_data2 !== exp_d) errs++;
                end
                rx++;
            end
            if (acc) q.push_back(6'(up_data2 + 6'd1));
            tick;
            if (acc) begin
                idx++;
                up_valid2 = 0;
            end
        end
        down_ready2 = 0;
        check("np_rx", rx, 200);
        check("np_errs", errs, 0);
        check("np_in_max_le3", max_in <= 3, 1);
        check("np_out_max_le5", max_out <= 5, 1);

        // Mid-stream asynchronous reset
        down_ready = 0; mode = 2'b10; idx = 0;
        for (int c = 0; c < 12 && idx < 5; c++) begin
            up_data = 6'(idx + 1); up_valid = 1;
            acc = up_ready;
            tick;
            if (acc) idx++;
        end
        up_valid = 0;
        tick;
        check("mr_pre_out_level", out_level, 4);
        #2 rst = 0;
        #1;
        check("mr_down_valid", down_valid, 0);
        check("mr_down_data", down_data, 0);
        check("mr_in_level", in_level, 0);
        check("mr_out_level", out_level, 0);
        check("mr_up_ready", up_ready, 0);
        @(posedge clk);
        #3 rst = 1;
        tick;
        mode = 2'b00; up_data = 6'h2A; up_valid = 1; down_ready = 1;
        tick;
        up_valid = 0;
        check("mr_lat_n", down_valid, 0);
        tick;
        check("mr_lat_n1", down_valid, 0);
        tick;
        check("mr_lat_n2_valid", down_valid, 1);
        check("mr_lat_n2_data", down_data, 6'h2A);
        tick;
        check("mr_alone_a", down_valid, 0);
        tick;
        check("mr_alone_b", down_valid, 0);

`ifdef STREAM_PROC_CNT_EN
        rst = 0; tick; rst = 1; tick;
        for (int k = 0; k < 7; k++) xfer(6'(k), 2'b00, g);
        down_ready = 0;
        for (int k = 0; k < 3; k++) begin
            up_data = 6'(k); up_valid = 1;
            tick;
        end
        up_valid = 0;
        repeat (3) tick;
        check("cnt_in_10", in_cnt, 10);
        check("cnt_out_7", out_cnt, 7);
        rst = 0; tick; rst = 1; tick;
        down_ready = 1; up_valid = 1; idx = 0;
        for (int c = 0; c < 70000 && idx < 65540; c++) begin
            acc = up_ready;
            tick;
            if (acc) idx++;
        end
        up_valid = 0;
        tick;
        check("cnt_force_accepts", idx, 65540);
        check("cnt_in_sat", in_cnt, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_proc_chain.md
Name: stream_proc_chain

Overview:
Parametrised successor to the FIFO→logic→FIFO stream chain: a valid/ready pipeline made of an input FIFO, a mode-selectable processing stage, and an output FIFO.
- FIFO depths are arbitrary and need not be powers of two.
- The processing operation is selected at run time.
- Both FIFOs export their occupancy.
- Sits between an upstream producer and a downstream consumer in a streaming datapath.

Parameters:
D_WIDTH, 6, data word width (>=2)
IN_DEPTH, 4, input FIFO entries (>=2, any integer)
OUT_DEPTH, 4, output FIFO entries (>=2, any integer)
ADD_CONST, 1, constant used by add modes (0..2^D_WIDTH-1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
up_data  input  D_WIDTH  upstream word
up_valid  input  1  upstream word valid
up_ready  output  1  block accepts word this cycle
down_data  output  D_WIDTH  downstream word
down_valid  output  1  downstream word valid
down_ready  input  1  downstream accepts word
mode  input  2  processing op: 00 pass, 01 wrap add, 10 invert, 11 saturating add
in_level  output  $clog2(IN_DEPTH+1)  input FIFO occupancy
out_level  output  $clog2(OUT_DEPTH+1)  output FIFO occupancy

Behaviour:
- Handshake:
  - Transfer on any port occurs at a rising edge with valid&&ready both high.
  - Once valid is high, data is held stable until transfer.
  - up_ready is never combinationally dependent on up_valid.
- Reset (rst=0, asynchronous):
  - FIFOs are empty, with all pointers and counts 0.
  - Stage register is invalid.
  - up_ready=0 while rst=0, then 1 from the first cycle after release.
  - down_valid=0, down_data=0, in_level=0, out_level=0.
  - Reset asserted mid-operation discards all in-flight words immediately.
- FIFOs:
  - Flop-based circular buffers.
  - Pointers wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two overflow.
  - Count register: full = (count==DEPTH), empty = (count==0).
  - Read data is registered, out of the head entry. No read-before-write bypass.
  - Input FIFO: up_ready = !full.
    - When full, a simultaneous pop does NOT enable a push in the same cycle.
    - Simultaneous push+pop when neither full nor empty leaves count unchanged.
  - Push into an empty FIFO becomes visible at its output on the cycle after the push edge.
- Processing stage:
  - Single register stage.
  - stage_ready = !stage_valid || out_fifo_not_full.
  - On input-FIFO pop, the stage captures f(data, mode). mode is sampled at that same edge.
  - Ops:
    - 00: pass-through.
    - 01: (d+ADD_CONST) mod 2^D_WIDTH.
    - 10: ~d.
    - 11: min(d+ADD_CONST, 2^D_WIDTH-1), computed on D_WIDTH+1 bits.
  - A mode change affects only words captured after the change.
- Output FIFO:
  - Pushed from the stage when stage_valid && !full.
  - down_valid = !empty, down_data = head entry.
- Latency: empty chain, no backpressure.
  - Word accepted at edge N is captured by the stage at edge N+1.
  - It is written to the output FIFO at edge N+2.
  - down_valid is high in the cycle following edge N+2.
- Throughput: 1 word/cycle sustained when down_ready is held high.
- Ordering: strict FIFO order. No word is lost or duplicated under any valid/ready pattern.
- Total buffering capacity: IN_DEPTH + 1 + OUT_DEPTH words.

Optional Feature:
STREAM_PROC_CNT_EN
- Defined:
  - Adds outputs in_cnt[15:0] (words accepted on up port) and out_cnt[15:0] (words delivered on down port).
  - Both counters saturate at 16'hFFFF and are cleared by rst.
- Not defined: the ports and counters are absent.
- Data behaviour is identical in both builds.

Test Plan:
- Single word: mode=01, ADD_CONST=1, up_data=6'h05 accepted at edge N, down_ready=1 → down_valid high after edge N+2, down_data=6'h06, then down_valid=0.
- Saturate vs wrap: up_data=6'h3F with mode=11 → down_data=6'h3F; same word with mode=01 → 6'h00; mode=10 on 6'h15 → 6'h2A.
- Backpressure fill: down_ready=0, stream 0..20 with up_valid=1 and mode=00 → exactly IN_DEPTH+1+OUT_DEPTH=9 words accepted; up_ready=0; in_level=4, out_level=4. Then down_ready=1 → 0..8 emerge in order, then 9..20 follow with no gap.
- Non-pow2 wrap: IN_DEPTH=3, OUT_DEPTH=5, random valid/ready toggling, 200 words → scoreboard matches in order; levels never exceed 3/5.
- Mid-stream reset: rst=0 asynchronously mid-transfer with 5 words in flight → outputs zero immediately; after release, a new word 6'h2A emerges alone with correct latency.
- Counters (macro on): 10 accepts, 7 deliveries → in_cnt=10, out_cnt=7. Force 65540 accepts → in_cnt=16'hFFFF.
